// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and encodings for the multicycle RV32I controller and datapath
// Holds the FSM state enum, opcode constants, ALU operation codes, ALUOp
// classes and the mux select encodings used by ResultSrc/ALUSrcA/ALUSrcB/ImmSrc.
package riscv_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp class plus instruction function fields to an ALU operation code
// Ports: alu_op (ALUOp class), funct3, op5 (Instr[5]), funct7b5 (Instr[30]) -> alu_control.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  logic r_sub;
  // Only R-type (op[5]=1) honours funct7b5; addi with imm[10]=1 must stay an add.
  assign r_sub = op5 & funct7b5;
  always_comb begin
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct3 == 3'b000    ? (r_sub ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010    ? ALU_SLT :
                  funct3 == 3'b110    ? ALU_OR :
                  funct3 == 3'b111    ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing a multicycle RV32I datapath
// Inputs: clk, rst (sync, active-low), op/funct3/funct7b5 from the IR, Zero from the ALU.
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
// ImmSrc, ALUControl, Illegal (sticky until reset), Retire pulse, InstrCount.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal,
  output logic             Retire,
  output logic [CNT_W-1:0] InstrCount
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pc_update, branch, ir_write, reg_write, mem_write, retire;
  logic [1:0]       alu_op;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                           op == OP_R   ? S_EXECR :
                           op == OP_I   ? S_EXECI :
                           op == OP_BEQ ? S_BEQ :
                           op == OP_JAL ? S_JAL : S_ILLEGAL;
      S_MEMADR:  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    retire    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end
  // Strobes are gated by rst so an instruction caught by reset never writes or retires.
  assign PCWrite    = rst & (pc_update | (branch & Zero));
  assign IRWrite    = rst & ir_write;
  assign RegWrite   = rst & reg_write;
  assign MemWrite   = rst & mem_write;
  assign Retire     = rst & retire;
  assign Illegal    = state_q == S_ILLEGAL;
  assign ImmSrc     = op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  assign count_d    = Retire ? count_q + CNT_W'(1) : count_q;
  assign InstrCount = count_q;
  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: self-checking bench for multicycle_controller
module tb_multicycle_controller;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, srca, srcb, imm;
    logic [2:0] aluc;
    logic       ill, ret;
  } outs_t;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] zmode;
    logic [2:0] aluc;
    logic       pcw;
    int         len;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [31:0] InstrCount;
  logic p4, a4, m4, i4, r4, l4, t4;
  logic [1:0] rs4, sa4, sb4, im4;
  logic [2:0] ac4;
  logic [3:0] cnt4;
  outs_t act;
  int n_checks = 0, n_err = 0;
  int unsigned cnt = 0;
  logic [2:0] obs_aluc;
  logic obs_pcw;
  int obs_len;
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal), .Retire(Retire),
    .InstrCount(InstrCount)
  );
  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(p4), .AdrSrc(a4), .MemWrite(m4), .IRWrite(i4), .RegWrite(r4),
    .ResultSrc(rs4), .ALUSrcA(sa4), .ALUSrcB(sb4), .ImmSrc(im4), .ALUControl(ac4),
    .Illegal(l4), .Retire(t4), .InstrCount(cnt4)
  );
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUControl, Illegal, Retire};
  function automatic logic [1:0] imm_ref(logic [6:0] o);
    return o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [2:0] alu_ref(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  function automatic int len_ref(logic [6:0] o);
    case (o)
      LW:      return 5;
      SW, RT, IT, JL: return 4;
      BQ:      return 3;
      default: return 22;
    endcase
  endfunction
  // Cycle k of an instruction (k=0 is fetch): what the datapath must be told to do.
  function automatic outs_t exp_out(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int k);
    outs_t e = '0;
    e.imm = imm_ref(o);
    if (k == 0) begin
      e.irw = 1; e.pcw = 1; e.srcb = 2; e.res = 2;
    end else if (k == 1) begin
      e.srca = 1; e.srcb = 1;
    end else if (o == LW || o == SW) begin
      if (k == 2) begin e.srca = 2; e.srcb = 1; end
      else if (o == SW) begin e.adr = 1; e.mw = 1; e.ret = 1; end
      else if (k == 3) e.adr = 1;
      else begin e.res = 1; e.rw = 1; e.ret = 1; end
    end else if (o == RT || o == IT) begin
      if (k == 2) begin e.srca = 2; e.srcb = o == IT ? 2'd1 : 2'd0; e.aluc = alu_ref(o, f3, f7); end
      else begin e.rw = 1; e.ret = 1; end
    end else if (o == JL) begin
      if (k == 2) begin e.srca = 1; e.srcb = 2; e.pcw = 1; end
      else begin e.rw = 1; e.ret = 1; end
    end else if (o == BQ) begin
      e.srca = 2; e.aluc = 3'b001; e.pcw = z; e.ret = 1;
    end else e.ill = 1;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic check_cycle(input outs_t e, input string tag);
    @(negedge clk);
    chk({tag, " outs"}, 32'(act), 32'(e));
    chk({tag, " cnt"}, InstrCount, cnt);
    chk({tag, " cnt4"}, 32'(cnt4), cnt % 16);
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [1:0] zmode);
    outs_t e;
    obs_len = 0;
    for (int k = 0; k < len_ref(o); k++) begin
      op = o; funct3 = f3; funct7b5 = f7;
      Zero = zmode == 2 ? 1'($urandom % 2) : zmode[0];
      e = exp_out(o, f3, f7, Zero, k);
      #0;
      if (k == 2) begin obs_aluc = ALUControl; obs_pcw = PCWrite; end
      if (Retire && obs_len == 0) obs_len = k + 1;
      check_cycle(e, $sformatf("op%b k%0d", o, k));
      if (e.ret) cnt++;
    end
  endtask
  task automatic reset_fetch();
    outs_t e;
    rst = 0;
    e = exp_out(op, funct3, funct7b5, Zero, 0);
    e.pcw = 0; e.irw = 0;
    check_cycle(e, "rst held");
    rst = 1;
    cnt = 0;
  endtask
  vec_t vt[10];
  initial begin
    outs_t e;
    vt[0] = '{RT, 3'b000, 1'b1, 2'd2, 3'b001, 1'b0, 4};
    vt[1] = '{RT, 3'b111, 1'b0, 2'd2, 3'b010, 1'b0, 4};
    vt[2] = '{IT, 3'b000, 1'b1, 2'd2, 3'b000, 1'b0, 4};
    vt[3] = '{RT, 3'b010, 1'b0, 2'd2, 3'b101, 1'b0, 4};
    vt[4] = '{RT, 3'b110, 1'b1, 2'd2, 3'b011, 1'b0, 4};
    vt[5] = '{IT, 3'b111, 1'b0, 2'd2, 3'b010, 1'b0, 4};
    vt[6] = '{BQ, 3'b000, 1'b0, 2'd1, 3'b001, 1'b1, 3};
    vt[7] = '{BQ, 3'b000, 1'b0, 2'd0, 3'b001, 1'b0, 3};
    vt[8] = '{LW, 3'b010, 1'b1, 2'd2, 3'b000, 1'b0, 5};
    vt[9] = '{JL, 3'b000, 1'b0, 2'd2, 3'b000, 1'b1, 4};
    @(posedge clk);
    #1;
    reset_fetch();
    chk("reset cnt", InstrCount, 0);
    chk("reset ill", 32'(Illegal), 0);
    run_instr(LW, 3'b010, 1'b1, 2'd0);
    chk("lw retired", InstrCount, 1);
    for (int i = 0; i < 10; i++) begin
      run_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].zmode);
      chk($sformatf("vec%0d aluc", i), 32'(obs_aluc), 32'(vt[i].aluc));
      chk($sformatf("vec%0d pcw", i), 32'(obs_pcw), 32'(vt[i].pcw));
      chk($sformatf("vec%0d len", i), obs_len, vt[i].len);
    end
    reset_fetch();
    for (int k = 0; k < 3; k++) begin
      op = SW; funct3 = 3'b010; funct7b5 = 1'b0;
      check_cycle(exp_out(SW, 3'b010, 1'b0, Zero, k), $sformatf("sw k%0d", k));
    end
    rst = 0;
    e = exp_out(SW, 3'b010, 1'b0, Zero, 3);
    e.mw = 0; e.ret = 0;
    check_cycle(e, "sw abort");
    rst = 1;
    chk("sw abort cnt", InstrCount, 0);
    run_instr(RT, 3'b000, 1'b0, 2'd2);
    reset_fetch();
    for (int i = 0; i < 15; i++) run_instr(IT, 3'($urandom), 1'($urandom), 2'd2);
    chk("wrap pre", 32'(cnt4), 15);
    run_instr(RT, 3'b110, 1'b0, 2'd2);
    chk("wrap post", 32'(cnt4), 0);
    for (int i = 0; i < 80; i++) begin
      logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 2'd2);
    end
    run_instr(7'b0000000, 3'b000, 1'b0, 2'd2);
    rst = 0;
    e = '0;
    e.ill = 1;
    check_cycle(e, "illegal rst");
    rst = 1;
    cnt = 0;
    run_instr(RT, 3'b000, 1'b1, 2'd2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
